// File: rtl/rv32_utils_pkg.sv
// Shared types and defaults for the rv32 retirement-trace capture path.
package rv32_utils;

  localparam int RV32_TRACE_SEQ_W  = 16;
  localparam int RV32_TRACE_HART_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } rv32_trace_state_e;

  typedef struct packed {
    logic [RV32_TRACE_HART_W-1:0] hart;
    logic [31:0]                  pc;
    logic [31:0]                  instr;
    logic [RV32_TRACE_SEQ_W-1:0]  seq;
  } rv32_trace_entry_t;

endpackage

// File: rtl/rv32_trace_fifo.sv
// First-word-fall-through FIFO; the head entry is visible on rdata_o while not empty.
module rv32_trace_fifo
  import rv32_utils::*;
#(
  parameter int  DEPTH   = 64,
  parameter type entry_t = rv32_trace_entry_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  entry_t                   wdata_i,
  input  logic                     pop_i,
  output entry_t                   rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t      mem [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  // Forcing zero when empty keeps the read port clean after reset or flush.
  assign rdata_o = empty_o ? '0 : mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rv32_trace_buffer.sv
// Retirement-trace capture: hart filtering, session FSM, sequence/drop accounting feeding a FWFT FIFO.
module rv32_trace_buffer
  import rv32_utils::*;
#(
  parameter int NUM_HARTS = 8,
  parameter int DEPTH     = 64,
  parameter int SEQ_W     = RV32_TRACE_SEQ_W
) (
  input  logic                         rv32_io_clk,
  input  logic                         rv32_io_rst_n,
  input  logic [NUM_HARTS-1:0]         hart_mask_i,
  input  logic                         arm_i,
  input  logic                         stop_i,
  input  logic                         end_i,
  input  logic                         wf_valid_i,
  input  logic [$clog2(NUM_HARTS)-1:0] wf_hart_i,
  input  logic [31:0]                  wf_pc_i,
  input  logic [31:0]                  wf_instr_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [$clog2(NUM_HARTS)-1:0] rd_hart_o,
  output logic [31:0]                  rd_pc_o,
  output logic [31:0]                  rd_instr_o,
  output logic [SEQ_W-1:0]             rd_seq_o,
  output logic [1:0]                   state_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [SEQ_W-1:0]             drop_cnt_o,
  output logic                         overflow_o
);

  localparam int HART_W = $clog2(NUM_HARTS);

  typedef struct packed {
    logic [HART_W-1:0] hart;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [SEQ_W-1:0]  seq;
  } entry_t;

  rv32_trace_state_e state_q, state_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [SEQ_W-1:0]  drop_q, drop_d;
  logic              ovf_q, ovf_d;

  logic   flush, qual, push, pop, drop, full, empty;
  entry_t wr_entry, rd_entry;

  // The end condition blocks capture in its own cycle, so the transition edge takes nothing.
  assign qual  = (state_q == ST_CAPTURE) && !(stop_i || end_i) &&
                 wf_valid_i && hart_mask_i[wf_hart_i];
  assign pop   = !empty && rd_ready_i;
  assign push  = qual && (!full || pop);
  assign drop  = qual && full && !pop;
  assign flush = (state_q == ST_IDLE) && arm_i;

  assign wr_entry = '{hart: wf_hart_i, pc: wf_pc_i, instr: wf_instr_i, seq: seq_q};

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE:    if (arm_i) state_d = ST_CAPTURE;
      ST_CAPTURE: if (stop_i || end_i) state_d = ST_DRAIN;
      ST_DRAIN:   if (empty || (pop && count_o == 1)) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (flush) begin
      seq_d  = '0;
      drop_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (qual) seq_d = seq_q + 1'b1;
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
    if (!rv32_io_rst_n) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  rv32_trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (rv32_io_clk),
    .rst_ni  (rv32_io_rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (rd_entry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  assign rd_valid_o = !empty;
  assign rd_hart_o  = rd_entry.hart;
  assign rd_pc_o    = rd_entry.pc;
  assign rd_instr_o = rd_entry.instr;
  assign rd_seq_o   = rd_entry.seq;
  assign state_o    = state_q;
  assign drop_cnt_o = drop_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_rv32_trace_buffer.sv
// Directed bench: a DEPTH=4 instance for overflow behaviour and a DEPTH=8 twin for the 5-entry reset case.
module tb_rv32_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  hart_mask;
  logic        arm, stop, end_in, wf_valid, rd_ready;
  logic [2:0]  wf_hart;
  logic [31:0] wf_pc, wf_instr;

  logic        rd_valid, b_rd_valid;
  logic [2:0]  rd_hart, b_rd_hart;
  logic [31:0] rd_pc, rd_instr, b_rd_pc, b_rd_instr;
  logic [15:0] rd_seq, drop_cnt, b_rd_seq, b_drop_cnt;
  logic [1:0]  state, b_state;
  logic [2:0]  count;
  logic [3:0]  b_count;
  logic        ovf, b_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32_trace_buffer #(.NUM_HARTS(8), .DEPTH(4), .SEQ_W(16)) u_dut (
    .rv32_io_clk(clk), .rv32_io_rst_n(rst_n), .hart_mask_i(hart_mask),
    .arm_i(arm), .stop_i(stop), .end_i(end_in),
    .wf_valid_i(wf_valid), .wf_hart_i(wf_hart), .wf_pc_i(wf_pc), .wf_instr_i(wf_instr),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_hart_o(rd_hart), .rd_pc_o(rd_pc),
    .rd_instr_o(rd_instr), .rd_seq_o(rd_seq), .state_o(state), .count_o(count),
    .drop_cnt_o(drop_cnt), .overflow_o(ovf)
  );

  rv32_trace_buffer #(.NUM_HARTS(8), .DEPTH(8), .SEQ_W(16)) u_big (
    .rv32_io_clk(clk), .rv32_io_rst_n(rst_n), .hart_mask_i(hart_mask),
    .arm_i(arm), .stop_i(stop), .end_i(end_in),
    .wf_valid_i(wf_valid), .wf_hart_i(wf_hart), .wf_pc_i(wf_pc), .wf_instr_i(wf_instr),
    .rd_valid_o(b_rd_valid), .rd_ready_i(rd_ready), .rd_hart_o(b_rd_hart), .rd_pc_o(b_rd_pc),
    .rd_instr_o(b_rd_instr), .rd_seq_o(b_rd_seq), .state_o(b_state), .count_o(b_count),
    .drop_cnt_o(b_drop_cnt), .overflow_o(b_ovf)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic event_in(input logic [2:0] h, input logic [31:0] pc, input logic [31:0] ins);
    wf_valid = 1'b1; wf_hart = h; wf_pc = pc; wf_instr = ins;
    step();
    wf_valid = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, state, 2'd0);
    chk({tag, "_count"}, count, 3'd0);
    chk({tag, "_rdbus"}, {rd_valid, rd_hart, rd_pc, rd_instr, rd_seq}, 84'd0);
    chk({tag, "_drop"},  {drop_cnt, ovf}, 17'd0);
    chk({tag, "_big"},   {b_state, b_count, b_rd_valid, b_rd_seq, b_rd_pc, b_drop_cnt, b_ovf}, 72'd0);
  endtask

  initial begin
    rst_n = 1'b0; hart_mask = 8'h00; arm = 0; stop = 0; end_in = 0;
    wf_valid = 0; wf_hart = 0; wf_pc = 0; wf_instr = 0; rd_ready = 0;
    #3;
    chk_reset_outputs("reset");
    #9 rst_n = 1'b1;

    // Hart-0-only capture of a round-robin stream
    hart_mask = 8'h01;
    arm = 1; step(); arm = 0;
    chk("t1_state_capture", state, 2'd1);
    for (int i = 0; i < 10; i++) begin
      wf_valid = 1; wf_hart = 3'(i % 8); wf_pc = 32'(4 * i); wf_instr = 32'h1000 + 32'(i);
      step();
    end
    wf_valid = 0;
    chk("t1_count", count, 3'd2);
    chk("t1_drop", {drop_cnt, ovf}, 17'd0);
    chk("t1_head0", {rd_valid, rd_hart, rd_pc, rd_instr, rd_seq}, {1'b1, 3'd0, 32'h0, 32'h1000, 16'd0});
    pop_one();
    chk("t1_head1", {rd_valid, rd_hart, rd_pc, rd_instr}, {1'b1, 3'd0, 32'h20, 32'h1008});
    pop_one();
    chk("t1_empty", {rd_valid, count}, 4'd0);
    stop = 1; step(); stop = 0;
    chk("t1_drain", state, 2'd2);
    step();
    chk("t1_idle", state, 2'd0);

    // Overflow into a 4-deep buffer with the consumer stalled
    hart_mask = 8'hff;
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 6; i++) event_in(3'(i), 32'h100 + 32'(4 * i), 32'h2000 + 32'(i));
    chk("t2_count", count, 3'd4);
    chk("t2_drop", drop_cnt, 16'd2);
    chk("t2_ovf", ovf, 1'b1);
    chk("t2_head", {rd_hart, rd_pc, rd_seq}, {3'd0, 32'h100, 16'd0});

    // Full buffer: simultaneous push and pop
    wf_valid = 1; wf_hart = 3'd3; wf_pc = 32'h200; wf_instr = 32'h3000; rd_ready = 1;
    step();
    wf_valid = 0; rd_ready = 0;
    chk("t3_count", count, 3'd4);
    chk("t3_drop", drop_cnt, 16'd2);
    chk("t3_seq1", rd_seq, 16'd1); pop_one();
    chk("t3_seq2", rd_seq, 16'd2); pop_one();
    chk("t3_seq3", rd_seq, 16'd3); pop_one();
    chk("t3_last", {rd_hart, rd_pc, rd_instr, rd_seq}, {3'd3, 32'h200, 32'h3000, 16'd6});
    pop_one();
    chk("t3_empty", {rd_valid, count}, 4'd0);

    // end_i with three entries stored
    for (int i = 0; i < 3; i++) event_in(3'(i), 32'h280 + 32'(4 * i), 32'h4000 + 32'(i));
    chk("t4_count", count, 3'd3);
    end_in = 1; wf_valid = 1; wf_hart = 3'd4; step(); end_in = 0; wf_valid = 0;
    chk("t4_drain", {state, count}, {2'd2, 3'd3});
    event_in(3'd5, 32'h2f0, 32'h4f00);
    chk("t4_ignored", {state, count}, {2'd2, 3'd3});
    chk("t4_head", {rd_hart, rd_pc, rd_seq}, {3'd0, 32'h280, 16'd7});
    pop_one();
    chk("t4_pop1", {state, count}, {2'd2, 3'd2});
    pop_one();
    chk("t4_pop2", {state, count}, {2'd2, 3'd1});
    pop_one();
    chk("t4_pop3", {state, count, rd_valid}, {2'd0, 3'd0, 1'b0});

    // Mid-session reset with five entries stored in the 8-deep instance
    rst_n = 0; #2 rst_n = 1;
    step();
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 5; i++) event_in(3'(i), 32'h300 + 32'(4 * i), 32'h5100 + 32'(i));
    chk("t5_big_count", {b_state, b_count, b_drop_cnt}, {2'd1, 4'd5, 16'd0});
    chk("t5_small_count", {count, drop_cnt}, {3'd4, 16'd1});
    #2 rst_n = 0;
    #1;
    chk_reset_outputs("t5_async");
    #1 rst_n = 1;
    arm = 1; step(); arm = 0;
    event_in(3'd5, 32'h400, 32'h5000);
    chk("t5_rearm", {rd_valid, rd_hart, rd_pc, rd_seq}, {1'b1, 3'd5, 32'h400, 16'd0});
    chk("t5_rearm_big", {b_rd_valid, b_rd_pc, b_rd_seq}, {1'b1, 32'h400, 16'd0});

    // Stalled consumer: head must stay put while masked events stream past
    hart_mask = 8'h00;
    for (int i = 0; i < 20; i++) begin
      wf_valid = 1; wf_hart = 3'(i % 8); wf_pc = $urandom; wf_instr = $urandom;
      step();
      chk("t6_hold", {rd_valid, rd_hart, rd_pc, rd_instr, rd_seq, count},
          {1'b1, 3'd5, 32'h400, 32'h5000, 16'd0, 3'd1});
    end
    wf_valid = 0;
    stop = 1; step(); stop = 0;
    chk("t6_drain", state, 2'd2);
    pop_one();
    chk("t6_idle", {state, count, rd_valid}, {2'd0, 3'd0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
